// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock user-interface controller:
// mode and cursor enumerations, time field widths, default field moduli.
package clock_ctrl_pkg;

    localparam int unsigned HOUR_W       = 5;
    localparam int unsigned MIN_W        = 6;
    localparam int unsigned DEF_HOUR_MOD = 24;
    localparam int unsigned DEF_MIN_MOD  = 60;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        CUR_HOUR = 2'd0,
        CUR_MIN  = 2'd1,
        CUR_SEC  = 2'd2
    } cursor_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo increment/decrement of a single time field (combinational).
// Ports:
//   inc      - increment request (wins over dec)
//   dec      - decrement request
//   value    - current field value
//   next_c   - value after the requested step, wrapping at MOD
module wrap_counter #(
    parameter int unsigned MOD = 60,
    parameter int unsigned W   = 6
) (
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic [W-1:0] next_c
);

    // Step with wrap in both directions: MOD-1 + 1 -> 0, 0 - 1 -> MOD-1.
    always_comb begin
        next_c = value;
        if (inc) begin
            next_c = (value >= W'(MOD - 1)) ? '0 : value + W'(1);
        end else if (dec) begin
            next_c = (value == '0) ? W'(MOD - 1) : value - W'(1);
        end
    end

endmodule

// File: rtl/mode_controller.sv
// Button-driven mode controller for a digital clock: selects between
// CLOCK / SET_TIME / SET_ALARM, edits a time buffer and the alarm
// registers, and strobes the edited time into the timekeeper.
// Ports:
//   i_clk, i_rstn                  - clock, synchronous active-low reset
//   i_up/i_down/i_left/i_right/i_mode - single-cycle button pulses
//   i_cur_hour/min/sec             - live timekeeper value
//   o_mode, o_cursor               - current mode and selected field
//   o_set_hour/min/sec             - time edit buffer
//   o_time_load                    - one-cycle load strobe for o_set_*
//   o_alarm_hour/min, o_alarm_en   - alarm registers
module mode_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned HOUR_MOD = DEF_HOUR_MOD,
    parameter int unsigned MIN_MOD  = DEF_MIN_MOD
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_left,
    input  logic              i_right,
    input  logic              i_mode,
    input  logic [HOUR_W-1:0] i_cur_hour,
    input  logic [MIN_W-1:0]  i_cur_min,
    input  logic [MIN_W-1:0]  i_cur_sec,
    output logic [1:0]        o_mode,
    output logic [1:0]        o_cursor,
    output logic [HOUR_W-1:0] o_set_hour,
    output logic [MIN_W-1:0]  o_set_min,
    output logic [MIN_W-1:0]  o_set_sec,
    output logic              o_time_load,
    output logic [HOUR_W-1:0] o_alarm_hour,
    output logic [MIN_W-1:0]  o_alarm_min,
    output logic              o_alarm_en
);

    mode_e             mode_q, mode_d;
    cursor_e           cursor_q, cursor_d;
    logic [HOUR_W-1:0] set_hour_q, set_hour_d;
    logic [MIN_W-1:0]  set_min_q, set_min_d;
    logic [MIN_W-1:0]  set_sec_q, set_sec_d;
    logic              time_load_q, time_load_d;
    logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
    logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
    logic              alarm_en_q, alarm_en_d;

    // Up beats down; the FSM decides which field actually takes the step.
    logic inc_c, dec_c;
    assign inc_c = i_up;
    assign dec_c = ~i_up & i_down;

    logic [HOUR_W-1:0] set_hour_next_c, alarm_hour_next_c;
    logic [MIN_W-1:0]  set_min_next_c, set_sec_next_c, alarm_min_next_c;

    wrap_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_set_hour (
        .inc(inc_c), .dec(dec_c), .value(set_hour_q), .next_c(set_hour_next_c));
    wrap_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_set_min (
        .inc(inc_c), .dec(dec_c), .value(set_min_q), .next_c(set_min_next_c));
    wrap_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_set_sec (
        .inc(inc_c), .dec(dec_c), .value(set_sec_q), .next_c(set_sec_next_c));
    wrap_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_alarm_hour (
        .inc(inc_c), .dec(dec_c), .value(alarm_hour_q), .next_c(alarm_hour_next_c));
    wrap_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_alarm_min (
        .inc(inc_c), .dec(dec_c), .value(alarm_min_q), .next_c(alarm_min_next_c));

    // Next-state logic: strict priority mode > left/right > up/down, one action per cycle.
    always_comb begin
        mode_d       = mode_q;
        cursor_d     = cursor_q;
        set_hour_d   = set_hour_q;
        set_min_d    = set_min_q;
        set_sec_d    = set_sec_q;
        time_load_d  = 1'b0;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_en_d   = alarm_en_q;

        if (i_mode) begin
            cursor_d = CUR_HOUR;
            case (mode_q)
                MODE_CLOCK: begin
                    mode_d     = MODE_SET_TIME;
                    set_hour_d = i_cur_hour;
                    set_min_d  = i_cur_min;
                    set_sec_d  = i_cur_sec;
                end
                MODE_SET_TIME: begin
                    mode_d      = MODE_SET_ALARM;
                    time_load_d = 1'b1;
                end
                default: mode_d = MODE_CLOCK;
            endcase
        end else if (i_left || i_right) begin
            // Left/right are consumed in every mode; in CLOCK they do nothing.
            if (mode_q == MODE_SET_TIME) begin
                if (i_left) begin
                    case (cursor_q)
                        CUR_HOUR: cursor_d = CUR_SEC;
                        CUR_MIN:  cursor_d = CUR_HOUR;
                        default:  cursor_d = CUR_MIN;
                    endcase
                end else begin
                    case (cursor_q)
                        CUR_HOUR: cursor_d = CUR_MIN;
                        CUR_MIN:  cursor_d = CUR_SEC;
                        default:  cursor_d = CUR_HOUR;
                    endcase
                end
            end else if (mode_q == MODE_SET_ALARM) begin
                cursor_d = (cursor_q == CUR_HOUR) ? CUR_MIN : CUR_HOUR;
            end
        end else if (i_up || i_down) begin
            case (mode_q)
                MODE_CLOCK: alarm_en_d = ~alarm_en_q;
                MODE_SET_TIME: begin
                    case (cursor_q)
                        CUR_HOUR: set_hour_d = set_hour_next_c;
                        CUR_MIN:  set_min_d  = set_min_next_c;
                        default:  set_sec_d  = set_sec_next_c;
                    endcase
                end
                default: begin
                    if (cursor_q == CUR_HOUR) alarm_hour_d = alarm_hour_next_c;
                    else                      alarm_min_d  = alarm_min_next_c;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            mode_q       <= MODE_CLOCK;
            cursor_q     <= CUR_HOUR;
            set_hour_q   <= '0;
            set_min_q    <= '0;
            set_sec_q    <= '0;
            time_load_q  <= 1'b0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            alarm_en_q   <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            cursor_q     <= cursor_d;
            set_hour_q   <= set_hour_d;
            set_min_q    <= set_min_d;
            set_sec_q    <= set_sec_d;
            time_load_q  <= time_load_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_en_q   <= alarm_en_d;
        end
    end

    assign o_mode       = mode_q;
    assign o_cursor     = cursor_q;
    assign o_set_hour   = set_hour_q;
    assign o_set_min    = set_min_q;
    assign o_set_sec    = set_sec_q;
    assign o_time_load  = time_load_q;
    assign o_alarm_hour = alarm_hour_q;
    assign o_alarm_min  = alarm_min_q;
    assign o_alarm_en   = alarm_en_q;

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 The block SHALL have parameter HOUR_MOD, default 24, meaning hour field modulus (legal 12 or 24).
REQ-002 The block SHALL have parameter MIN_MOD, default 60, meaning minute/second field modulus.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: i_clk  in  1  rising-edge clock; i_rstn  in  1  synchronous active-low reset.
REQ-004 The block SHALL have these button inputs: i_up, i_down, i_left, i_right, i_mode  in  1 each  single-cycle press pulses, already edge-detected upstream.
REQ-005 The block SHALL have i_cur_hour  in  5, i_cur_min  in  6, i_cur_sec  in  6  live timekeeper value.
REQ-006 The block SHALL have o_mode  out  2  current mode: 0 CLOCK, 1 SET_TIME, 2 SET_ALARM.
REQ-007 The block SHALL have o_cursor  out  2  selected field: 0 HOUR, 1 MIN, 2 SEC.
REQ-008 The block SHALL have o_set_hour  out  5, o_set_min  out  6, o_set_sec  out  6  time edit buffer.
REQ-009 The block SHALL have o_time_load  out  1  one-cycle strobe that loads o_set_* into the timekeeper.
REQ-010 The block SHALL have o_alarm_hour  out  5, o_alarm_min  out  6, o_alarm_en  out  1  alarm registers.

Function
REQ-011 All outputs SHALL be registered; a press takes effect on the clock edge at which it is sampled and is visible one cycle later.
REQ-012 The mode FSM SHALL cycle CLOCK -> SET_TIME -> SET_ALARM -> CLOCK on each i_mode pulse; there are no other transitions.
REQ-013 On CLOCK -> SET_TIME, the FSM SHALL copy i_cur_hour/min/sec into o_set_* and set o_cursor to HOUR on the same edge.
REQ-014 On SET_TIME -> SET_ALARM, the FSM SHALL assert o_time_load for exactly one cycle, with o_set_* stable during that cycle.
REQ-015 On entering SET_ALARM, o_cursor SHALL be HOUR; on entering CLOCK, o_cursor SHALL be HOUR.
REQ-016 In SET_TIME, i_right SHALL advance the cursor HOUR -> MIN -> SEC -> HOUR, and i_left SHALL move it in reverse, with wrap at both ends.
REQ-017 In SET_ALARM, the cursor SHALL range over HOUR and MIN only; i_left and i_right both toggle between them.
REQ-018 In SET_TIME and SET_ALARM, i_up SHALL increment the selected field modulo its modulus, and i_down SHALL decrement it modulo its modulus (0 - 1 -> modulus - 1).
REQ-019 In SET_TIME, field updates SHALL target o_set_*; in SET_ALARM, they SHALL target o_alarm_hour/min.
REQ-020 In CLOCK mode, i_up or i_down SHALL toggle o_alarm_en, and i_left and i_right SHALL be ignored.
REQ-021 When pulses coincide, exactly one action SHALL be taken per cycle, with priority i_mode > i_left/i_right > i_up/i_down; i_left beats i_right and i_up beats i_down.
REQ-022 No press SHALL be queued; lower-priority simultaneous presses SHALL be discarded.
REQ-023 o_set_* SHALL hold their value outside SET_TIME.
REQ-024 o_time_load SHALL never assert except as specified in REQ-014.

Reset
REQ-025 While i_rstn is low at a rising edge, the block SHALL apply these values: o_mode CLOCK, o_cursor HOUR, o_set_* 0, o_alarm_hour 0, o_alarm_min 0, o_alarm_en 0, o_time_load 0.
REQ-026 Reset in SET_TIME SHALL discard the edit buffer without asserting o_time_load.
REQ-027 Reset in the cycle where o_time_load would have asserted SHALL keep it at 0.

Structure
REQ-028 Shared package clock_ctrl_pkg SHALL hold the mode and cursor enumerations, the field widths (5/6), and default moduli.
REQ-029 Sub-module wrap_counter SHALL perform modulo increment/decrement of one field (parameter MOD; inputs inc, dec, value), instantiated per editable field.

Verification
REQ-030 Reset, then mode pulse with cur=13:45:30 -> o_mode=1, o_set=13:45:30, o_cursor=0.
REQ-031 In SET_TIME at hour 23, up -> hour 0; right twice, then down at sec 0 -> sec 59; left from HOUR -> cursor SEC.
REQ-032 Edit to 08:15:00, then mode -> o_time_load=1 for one cycle only with o_set=08:15:00, o_mode=2.
REQ-033 In SET_ALARM, right, then up at min 59 -> alarm_min 0; right from MIN -> HOUR; mode -> o_mode=0 with no o_time_load.
REQ-034 Simultaneous i_mode+i_up in SET_TIME -> mode advances, field unchanged; simultaneous i_up+i_down -> increment only.
REQ-035 Reset asserted mid-SET_TIME after edits -> all outputs at reset values, o_time_load stays 0; i_up in CLOCK -> o_alarm_en=1.
